// File: rtl/instr_encoder_loader.sv
// Encodes abstract ALU/load operations into RV32 instruction words, queues them in a small
// FIFO and streams them into instruction memory. Optional build macro: ILLEGAL_TRAP_EN.
module instr_encoder_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_alu_op,
  input  logic              in_load,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Returns {legal, word}; word is meaningless when legal is 0.
  function automatic logic [32:0] encode_op(
    input logic        load,
    input logic [3:0]  alu_op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [31:0] word;
    logic        legal;
    word  = 32'h0000_0000;
    legal = 1'b1;
    case ({load, alu_op})
      5'b1_0000: word = {imm, rs1, 3'b010, rd, 7'b0000011};
      5'b0_0001: word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      5'b0_0010: word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      5'b0_0011: word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      5'b0_0100: word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      5'b0_0101: word = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
    return {legal, word};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W-1:0]  count_r;
  logic               err_r;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic               trap_s;
  logic               start_s;
  logic [32:0]        enc_s;
  logic               legal_s;
  logic [31:0]        push_word_s;

  assign fifo_full_s  = (occ_r == OCC_FULL);
  assign fifo_empty_s = (occ_r == {OCC_W{1'b0}});
  assign in_ready_s   = (state_r == ST_RUN) && !fifo_full_s;
  assign accept_s     = in_valid && in_ready_s;
  assign pop_s        = !fifo_empty_s && imem_ready;
  assign start_s      = (state_r == ST_IDLE) && start;

  assign enc_s   = encode_op(in_load, in_alu_op, in_rd, in_rs1, in_rs2, in_imm);
  assign legal_s = enc_s[32];

`ifdef ILLEGAL_TRAP_EN
  // Illegal requests complete the handshake but never reach the FIFO.
  assign push_word_s = enc_s[31:0];
  assign push_s      = accept_s && legal_s;
  assign trap_s      = accept_s && !legal_s;
`else
  assign push_word_s = legal_s ? enc_s[31:0] : NOP_WORD;
  assign push_s      = accept_s;
  assign trap_s      = 1'b0;
`endif

  // Session state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DRAIN waits until the last queued word has been written.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && in_last) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // FIFO storage; contents are only observable through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // Write address, written-word count and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r  <= {ADDR_W{1'b0}};
      count_r <= {ADDR_W{1'b0}};
      err_r   <= 1'b0;
    end else if (start_s) begin
      addr_r  <= base_addr;
      count_r <= {ADDR_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        addr_r  <= addr_r + ADDR_W'(1);
        count_r <= count_r + ADDR_W'(1);
      end
      if (trap_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign imem_we    = !fifo_empty_s;
  assign imem_addr  = addr_r;
  assign imem_wdata = fifo_empty_s ? 32'h0000_0000 : fifo_mem_r[rd_ptr_r];
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign err        = err_r;
  assign count      = count_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: encoding table, directed multi-cycle corners and
// randomized sessions against an arithmetic reference model of the instruction formats.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        load;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } op_t;

  typedef struct {
    op_t         op;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_alu_op;
  logic              in_load;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [11:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] count;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_alu_op(in_alu_op), .in_load(in_load), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  int  chk_total = 0;
  int  chk_pass  = 0;
  int  done_cnt  = 0;
  int  acc_cnt   = 0;
  int  ready_mode = 0;
  op_t ops[$];
  logic [39:0] wr_log[$];
  vec_t tbl [11];
  longint f3_tab [0:5] = '{64'd0, 64'd0, 64'd0, 64'd6, 64'd7, 64'd4};
  longint f7_tab [0:5] = '{64'd0, 64'd0, 64'd32, 64'd0, 64'd0, 64'd0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic op_t mk_op(input logic load, input logic [3:0] alu, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    op_t o;
    o.load = load; o.alu = alu; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
    return o;
  endfunction

  function automatic bit is_legal(input op_t o);
    return (o.load && o.alu == 4'd0) || (!o.load && o.alu >= 4'd1 && o.alu <= 4'd5);
  endfunction

  // Reference encoder: {word is written, word} from field weights of the RV32 formats.
  function automatic logic [32:0] ref_encode(input op_t o);
    longint w;
    if (!is_legal(o)) return {!TRAP, 32'h0000_0013};
    if (o.load)
      w = longint'(o.imm) * 64'd1048576 + longint'(o.rs1) * 64'd32768 + 64'd8192
        + longint'(o.rd) * 64'd128 + 64'd3;
    else
      w = f7_tab[int'(o.alu)] * 64'd33554432 + longint'(o.rs2) * 64'd1048576
        + longint'(o.rs1) * 64'd32768 + f3_tab[int'(o.alu)] * 64'd4096
        + longint'(o.rd) * 64'd128 + 64'd51;
    return {1'b1, w[31:0]};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o = mk_op(1'($urandom_range(0, 1)), 4'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)));
    if ($urandom_range(0, 9) == 0) o.alu = o.load ? 4'($urandom_range(1, 15)) : 4'($urandom_range(6, 15));
    else o.alu = o.load ? 4'd0 : 4'($urandom_range(1, 5));
    return o;
  endfunction

  // imem_ready pattern: 0 = always ready, 1 = stalled, other = random back-pressure.
  initial begin
    imem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       imem_ready = 1'b1;
        1:       imem_ready = 1'b0;
        default: imem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: write log, done/accept counts, stability of a stalled write.
  initial begin
    bit          stall_prev = 1'b0;
    logic [7:0]  hold_addr = 8'h00;
    logic [31:0] hold_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && stall_prev && imem_we) begin
        check("stall_addr_stable", 64'(imem_addr), 64'(hold_addr));
        check("stall_data_stable", 64'(imem_wdata), 64'(hold_data));
      end
      stall_prev = rst_n && imem_we && !imem_ready;
      hold_addr  = imem_addr;
      hold_data  = imem_wdata;
      if (rst_n && imem_we && imem_ready) wr_log.push_back({imem_addr, imem_wdata});
      if (done) done_cnt++;
      if (in_valid && in_ready) acc_cnt++;
    end
  end

  task automatic start_pulse(input logic [7:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_ops();
    for (int i = 0; i < ops.size(); i++) begin
      int waited = 0;
      in_valid = 1'b1; in_last = (i == ops.size() - 1);
      in_load = ops[i].load; in_alu_op = ops[i].alu; in_rd = ops[i].rd;
      in_rs1 = ops[i].rs1; in_rs2 = ops[i].rs2; in_imm = ops[i].imm;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("accept_in_ready", 64'(in_ready), 64'(1));
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_session(input logic [7:0] base);
    logic [39:0] exp_q[$];
    logic [7:0]  a = base;
    logic [32:0] r;
    bit          any_illegal = 1'b0;
    int          d0 = done_cnt;
    int          w = 0;
    foreach (ops[i]) begin
      r = ref_encode(ops[i]);
      if (!is_legal(ops[i])) any_illegal = 1'b1;
      if (r[32]) begin
        exp_q.push_back({a, r[31:0]});
        a = a + 8'd1;
      end
    end
    wr_log.delete();
    start_pulse(base);
    push_ops();
    while (done_cnt == d0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("done_pulses", 64'(done_cnt - d0), 64'(1));
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("count", 64'(count), 64'(exp_q.size()));
    check("err", 64'(err), 64'(any_illegal && TRAP));
    check("num_writes", 64'(wr_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      check("wr_addr", 64'(wr_log[i][39:32]), 64'(exp_q[i][39:32]));
      check("wr_data", 64'(wr_log[i][31:0]), 64'(exp_q[i][31:0]));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_alu_op = 4'd0; in_load = 1'b0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 12'd0;

    tbl[0]  = '{mk_op(1'b0, 4'd1, 5'd3,  5'd1,  5'd2,  12'h5A5), 1'b1, 32'h002081B3};
    tbl[1]  = '{mk_op(1'b0, 4'd2, 5'd5,  5'd6,  5'd7,  12'h000), 1'b1, 32'h407302B3};
    tbl[2]  = '{mk_op(1'b1, 4'd0, 5'd4,  5'd2,  5'd9,  12'h008), 1'b1, 32'h00812203};
    tbl[3]  = '{mk_op(1'b0, 4'd3, 5'd1,  5'd2,  5'd3,  12'h000), 1'b1, 32'h003160B3};
    tbl[4]  = '{mk_op(1'b0, 4'd4, 5'd10, 5'd11, 5'd12, 12'h000), 1'b1, 32'h00C5F533};
    tbl[5]  = '{mk_op(1'b0, 4'd5, 5'd31, 5'd30, 5'd29, 12'h000), 1'b1, 32'h01DF4FB3};
    tbl[6]  = '{mk_op(1'b1, 4'd0, 5'd7,  5'd31, 5'd0,  12'hFFF), 1'b1, 32'hFFFFA383};
    tbl[7]  = '{mk_op(1'b0, 4'd7, 5'd1,  5'd1,  5'd1,  12'h000), 1'b0, 32'h00000013};
    tbl[8]  = '{mk_op(1'b1, 4'd1, 5'd2,  5'd3,  5'd4,  12'h010), 1'b0, 32'h00000013};
    tbl[9]  = '{mk_op(1'b0, 4'd0, 5'd2,  5'd3,  5'd4,  12'h000), 1'b0, 32'h00000013};
    tbl[10] = '{mk_op(1'b0, 4'd2, 5'd0,  5'd0,  5'd0,  12'hABC), 1'b1, 32'h40000033};

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_imem_we", 64'(imem_we), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Encoding table, one single-op session per entry.
    for (int i = 0; i < 11; i++) begin
      ops.delete();
      ops.push_back(tbl[i].op);
      run_session(8'(8'h20 + i));
      check("tbl_writes", 64'(wr_log.size()), 64'(tbl[i].legal || !TRAP));
      if (wr_log.size() > 0) check("tbl_word", 64'(wr_log[0][31:0]), 64'(tbl[i].word));
      check("tbl_err", 64'(err), 64'(!tbl[i].legal && TRAP));
    end

    // Two-op session, explicit words.
    ops.delete();
    ops.push_back(tbl[1].op);
    ops.push_back(tbl[2].op);
    run_session(8'h30);
    if (wr_log.size() == 2) begin
      check("pair_w0", 64'(wr_log[0]), 64'({8'h30, 32'h407302B3}));
      check("pair_w1", 64'(wr_log[1]), 64'({8'h31, 32'h00812203}));
    end else check("pair_size", 64'(wr_log.size()), 64'(2));

    // Back-pressure: DEPTH+1 ops with memory stalled, then released.
    begin
      int a0;
      logic [32:0] h;
      ops.delete();
      for (int i = 0; i < DEPTH + 1; i++) ops.push_back(mk_op(1'b0, 4'(1 + i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 12'h000));
      h = ref_encode(ops[0]);
      ready_mode = 1;
      a0 = acc_cnt;
      fork
        run_session(8'h50);
        begin
          repeat (DEPTH + 8) @(negedge clk);
          check("hold_accepts", 64'(acc_cnt - a0), 64'(DEPTH));
          check("hold_in_ready", 64'(in_ready), 64'(0));
          check("hold_we", 64'(imem_we), 64'(1));
          check("hold_addr", 64'(imem_addr), 64'(8'h50));
          check("hold_head", 64'(imem_wdata), 64'(h[31:0]));
          ready_mode = 0;
        end
      join
    end

    // Address wrap.
    ops.delete();
    ops.push_back(tbl[3].op);
    ops.push_back(tbl[4].op);
    run_session(8'hFF);
    if (wr_log.size() == 2) begin
      check("wrap_a0", 64'(wr_log[0][39:32]), 64'(8'hFF));
      check("wrap_a1", 64'(wr_log[1][39:32]), 64'(8'h00));
    end else check("wrap_size", 64'(wr_log.size()), 64'(2));

    // Reset while draining three queued words.
    begin
      int d0;
      ops.delete();
      for (int i = 0; i < 3; i++) ops.push_back(tbl[i].op);
      ready_mode = 1;
      wr_log.delete();
      d0 = done_cnt;
      start_pulse(8'h40);
      push_ops();
      @(negedge clk);
      check("drain_busy", 64'(busy), 64'(1));
      check("drain_we", 64'(imem_we), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_we", 64'(imem_we), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_count", 64'(count), 64'(0));
      ready_mode = 0;
      repeat (6) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'(0));
      check("abort_no_write", 64'(wr_log.size()), 64'(0));
      @(posedge clk); #1;
      ops.delete();
      ops.push_back(tbl[0].op);
      ops.push_back(tbl[5].op);
      run_session(8'h60);
    end

    // Randomized sessions with random back-pressure.
    ready_mode = 2;
    for (int s = 0; s < 25; s++) begin
      int n = $urandom_range(1, 7);
      ops.delete();
      for (int i = 0; i < n; i++) ops.push_back(rand_op());
      run_session(8'($urandom_range(0, 255)));
    end
    ready_mode = 0;

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Produces the instruction words that the control_unit decoder consumes: the encode direction of the same opcode/func3/func7 interface.
- Accepts abstract operations {alu_op, load flag, rd, rs1, rs2, imm} over a valid/ready handshake and encodes each into a 32-bit RISC-V R-type or load word.
- Buffers encoded words in a small FIFO, then writes them sequentially into instruction memory from a base address.
- Used by the bench and boot path to load programs.

Parameters:
- DEPTH, 4, encoded-word FIFO entries; power of 2, minimum 2.
- ADDR_W, 8, instruction memory word-address width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse in IDLE begins a load session at base_addr.
- base_addr  input  ADDR_W  first write address, sampled on start.
- in_valid  input  1  operation request valid.
- in_ready  output  1  request accepted this cycle when in_valid & in_ready.
- in_last  input  1  marks the final operation of the session.
- in_alu_op  input  4  0001 add, 0010 sub, 0011 or, 0100 and, 0101 xor, 0000 with in_load=1 means load.
- in_load  input  1  1 = load (I-type), 0 = R-type.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_imm  input  12  load offset; ignored for R-type.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  32  encoded instruction.
- imem_ready  input  1  memory accepts the write when imem_we & imem_ready.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when the session completes.
- err  output  1  sticky illegal-operation flag; cleared on start.
- count  output  ADDR_W  words written this session.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State=IDLE; FIFO emptied.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, count=0.
- Encoding (combinational, at push):
  - R-type word = {func7, rs2, rs1, func3, rd, 7'b0110011}.
  - add: func7=0000000, func3=000. sub: func7=0100000, func3=000. xor: func7=0, func3=100. or: func7=0, func3=110. and: func7=0, func3=111.
  - Load word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011}.
  - Illegal: in_load=1 with alu_op≠0000, or in_load=0 with alu_op outside 0001–0101. Handling is set by the optional feature below.
- State machine:
  - IDLE -> RUN on start: addr←base_addr, count←0, err←0. start while busy is ignored.
  - RUN: in_ready = !fifo_full. On an accepted request the encoded word is pushed. An accepted request with in_last=1 -> DRAIN; no further requests are accepted.
  - DRAIN: in_ready=0. Moves to DONE once the FIFO is empty and no write is pending.
  - DONE: done=1 for exactly one cycle, then IDLE.
- FIFO:
  - Full: in_ready=0. No push-on-pop while full.
  - Empty: imem_we=0.
  - A simultaneous push and pop when not full is legal; occupancy is unchanged.
- Write port:
  - imem_we = !fifo_empty. imem_wdata = FIFO head.
  - imem_wdata and imem_addr hold stable while imem_we=1 and imem_ready=0.
  - On imem_we & imem_ready: pop, imem_addr+1, count+1.
  - imem_addr wraps modulo 2^ADDR_W with no flag.
- Latency: an accepted request reaches imem_we at the earliest on the next cycle.
- Reset mid-session aborts the session, discards FIFO contents and produces no done pulse.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal request is accepted (handshake completes) but not pushed; err is set. in_last on an illegal request still ends the session.
- ILLEGAL_TRAP_EN undefined: an illegal request is encoded as NOP 0x00000013 (addi x0,x0,0) and written normally; err stays 0.

Test Plan:
- start with base_addr=0x10; push add rd=3 rs1=1 rs2=2 (in_last=1); imem_ready=1 -> single write 0x002081B3 at 0x10, count=1, done pulse, busy falls.
- Push sub rd=5 rs1=6 rs2=7, then load rd=4 rs1=2 imm=8 (last) -> 0x407302B3 @base, 0x00812203 @base+1.
- Hold imem_ready=0, push DEPTH+1 ops -> in_ready drops after DEPTH accepts; wdata/addr stable; release -> all words written in order, none lost or duplicated.
- base_addr=0xFF, ADDR_W=8, push 2 ops -> writes at 0xFF then 0x00, count=2.
- Push alu_op=0111 -> with ILLEGAL_TRAP_EN: err=1, no write for it. Without ILLEGAL_TRAP_EN: write 0x00000013, err=0.
- Assert rst_n=0 during DRAIN with 3 entries queued -> next cycle imem_we=0, busy=0, no done pulse; a new start runs normally.
